// File: rtl/csc_yuv2rgb_seq.sv
// Sequential YUV->RGB colour-space converter: one shared multiplier, 14 cycles per pixel pair.
// Optional build macro CSC_ROUND_EN adds round-to-nearest before the clip/shift.
module csc_yuv2rgb_seq #(
  parameter int unsigned Y_OFFSET  = 16,
  parameter int unsigned UV_OFFSET = 128,
  parameter int unsigned ACC_W     = 48
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] Y_word,
  input  logic [31:0] U_even,
  input  logic [31:0] U_odd,
  input  logic [31:0] V_even,
  input  logic [31:0] V_odd,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  typedef enum logic [3:0] {
    StIdle, StCy0, StCrv0, StCgu0, StCgv0, StCbu0,
    StCy1, StCrv1, StCgu1, StCgv1, StCbu1,
    StOut0, StOut1, StOut2
  } state_e;

  // Coefficient magnitudes; signs are folded into the accumulate (add vs subtract).
  localparam logic [17:0] CoefY  = 18'd76284;
  localparam logic [17:0] CoefRv = 18'd104595;
  localparam logic [17:0] CoefGu = 18'd25624;
  localparam logic [17:0] CoefGv = 18'd53281;
  localparam logic [17:0] CoefBu = 18'd132251;

  state_e state_q, state_d;

  logic [15:0] y_q;
  logic [31:0] ue_q, uo_q, ve_q, vo_q;

  logic signed [ACC_W-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [7:0] r0_q, r0_d, g0_q, g0_d, b0_q, b0_d;

  logic signed [31:0]      mul_a;
  logic [17:0]             mul_b;
  logic signed [ACC_W-1:0] a_ext, b_ext, prod;
  logic [7:0]              r1, g1, b1;

  function automatic logic [7:0] clip8(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] v;
`ifdef CSC_ROUND_EN
    v = acc + ACC_W'(32768);
`else
    v = acc;
`endif
    if (v[ACC_W-1]) begin
      return 8'd0;
    end else if (v[ACC_W-1:16] > (ACC_W-16)'(255)) begin
      return 8'hff;
    end else begin
      return v[23:16];
    end
  endfunction

  assign in_ready = (state_q == StIdle) && !reset;

  // Operand select: offset-removed sample and coefficient for the current step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StCy0:           begin mul_a = {24'd0, y_q[15:8]} - 32'(Y_OFFSET); mul_b = CoefY;  end
      StCrv0:          begin mul_a = ve_q - 32'(UV_OFFSET);              mul_b = CoefRv; end
      StCgu0:          begin mul_a = ue_q - 32'(UV_OFFSET);              mul_b = CoefGu; end
      StCgv0:          begin mul_a = ve_q - 32'(UV_OFFSET);              mul_b = CoefGv; end
      StCbu0:          begin mul_a = ue_q - 32'(UV_OFFSET);              mul_b = CoefBu; end
      StCy1:           begin mul_a = {24'd0, y_q[7:0]} - 32'(Y_OFFSET);  mul_b = CoefY;  end
      StCrv1:          begin mul_a = vo_q - 32'(UV_OFFSET);              mul_b = CoefRv; end
      StCgu1:          begin mul_a = uo_q - 32'(UV_OFFSET);              mul_b = CoefGu; end
      StCgv1:          begin mul_a = vo_q - 32'(UV_OFFSET);              mul_b = CoefGv; end
      StCbu1:          begin mul_a = uo_q - 32'(UV_OFFSET);              mul_b = CoefBu; end
      default: ;
    endcase
  end

  // Product kept at ACC_W bits, i.e. the sign-truncated low part of the full product.
  always_comb begin
    a_ext = ACC_W'(mul_a);
    b_ext = ACC_W'($signed({1'b0, mul_b}));
    prod  = a_ext * b_ext;
  end

  always_comb begin
    acc_r_d = acc_r_q;
    acc_g_d = acc_g_q;
    acc_b_d = acc_b_q;
    unique case (state_q)
      StCy0, StCy1: begin
        acc_r_d = prod;
        acc_g_d = prod;
        acc_b_d = prod;
      end
      StCrv0, StCrv1:                 acc_r_d = acc_r_q + prod;
      StCgu0, StCgu1, StCgv0, StCgv1: acc_g_d = acc_g_q - prod;
      StCbu0, StCbu1:                 acc_b_d = acc_b_q + prod;
      default: ;
    endcase
  end

  assign r1 = clip8(acc_r_q);
  assign g1 = clip8(acc_g_q);
  assign b1 = clip8(acc_b_q);

  // Even-pixel results are final on entry to StCy1 and must be saved before it reloads.
  always_comb begin
    r0_d = r0_q;
    g0_d = g0_q;
    b0_d = b0_q;
    if (state_q == StCy1) begin
      r0_d = r1;
      g0_d = g1;
      b0_d = b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StCy0;
      StCy0:  state_d = StCrv0;
      StCrv0: state_d = StCgu0;
      StCgu0: state_d = StCgv0;
      StCgv0: state_d = StCbu0;
      StCbu0: state_d = StCy1;
      StCy1:  state_d = StCrv1;
      StCrv1: state_d = StCgu1;
      StCgu1: state_d = StCgv1;
      StCgv1: state_d = StCbu1;
      StCbu1: state_d = StOut0;
      StOut0: if (out_ready) state_d = StOut1;
      StOut1: if (out_ready) state_d = StOut2;
      StOut2: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      StOut0: begin out_valid = 1'b1; out_data = {r0_q, g0_q}; end
      StOut1: begin out_valid = 1'b1; out_data = {b0_q, r1};   end
      StOut2: begin out_valid = 1'b1; out_data = {g1, b1}; out_last = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q <= StIdle;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
      r0_q    <= '0;
      g0_q    <= '0;
      b0_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_r_q <= acc_r_d;
      acc_g_q <= acc_g_d;
      acc_b_q <= acc_b_d;
      r0_q    <= r0_d;
      g0_q    <= g0_d;
      b0_q    <= b0_d;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (in_valid && in_ready) begin
      y_q  <= Y_word;
      ue_q <= U_even;
      uo_q <= U_odd;
      ve_q <= V_even;
      vo_q <= V_odd;
    end
  end

endmodule
